// File: rtl/axil_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : axil_pkg
//  Purpose  : Shared response codes and FSM state encodings for the
//             AXI4-Lite memory responder.
//  Revision : 1.0  initial release
// ============================================================================
package axil_pkg;

   // AXI response codes used by the responder
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // Write channel FSM
   typedef enum logic [1:0] {
      W_IDLE      = 2'd0,
      W_NEED_DATA = 2'd1,
      W_NEED_ADDR = 2'd2,
      W_RESP      = 2'd3
   } wr_state_e;

   // Read channel FSM
   typedef enum logic [0:0] {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } rd_state_e;

endpackage
`default_nettype wire

// File: rtl/axil_mem_array.sv
`default_nettype none
// ============================================================================
//  Module   : axil_mem_array
//  Purpose  : Word-addressed storage with a synchronous byte-enable write
//             port and a registered read port. Contents are never reset.
//  Revision : 1.0  initial release
// ============================================================================
module axil_mem_array #(
   parameter int DATA_WIDTH = 32,
   parameter int IDX_WIDTH  = 6
) (
   input  logic                    clk,
   input  logic                    wr_en,
   input  logic [IDX_WIDTH-1:0]    wr_idx,
   input  logic [DATA_WIDTH-1:0]   wr_data,
   input  logic [DATA_WIDTH/8-1:0] wr_strb,
   input  logic                    rd_en,
   input  logic [IDX_WIDTH-1:0]    rd_idx,
   output logic [DATA_WIDTH-1:0]   rd_data
);

   localparam int LANES = DATA_WIDTH / 8;
   localparam int DEPTH = 2 ** IDX_WIDTH;

   // One 8-bit bank per byte lane so each strobe bit owns its own storage.
   for (genvar lane = 0; lane < LANES; lane++) begin : g_lane
      logic [7:0] bank [DEPTH];

      // Byte-lane write, gated by the lane strobe
      always_ff @(posedge clk) begin
         if (wr_en && wr_strb[lane]) begin
            bank[wr_idx] <= wr_data[8*lane +: 8];
         end
      end

      // Registered read; same-edge write is not visible (old value returned)
      always_ff @(posedge clk) begin
         if (rd_en) begin
            rd_data[8*lane +: 8] <= bank[rd_idx];
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/axil_mem_slave.sv
`default_nettype none
// ============================================================================
//  Module   : axil_mem_slave
//  Purpose  : AXI4-Lite responder backed by a byte-enable memory. Independent
//             write and read FSMs; misaligned accesses answer SLVERR.
//  Revision : 1.0  initial release
// ============================================================================
module axil_mem_slave
   import axil_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                    s_axi_aclk,
   input  logic                    s_axi_areset,
   input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
   input  logic                    s_axi_awvalid,
   output logic                    s_axi_awready,
   input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
   input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
   input  logic                    s_axi_wvalid,
   output logic                    s_axi_wready,
   output logic [1:0]              s_axi_bresp,
   output logic                    s_axi_bvalid,
   input  logic                    s_axi_bready,
   input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
   input  logic                    s_axi_arvalid,
   output logic                    s_axi_arready,
   output logic [DATA_WIDTH-1:0]   s_axi_rdata,
   output logic [1:0]              s_axi_rresp,
   output logic                    s_axi_rvalid,
   input  logic                    s_axi_rready
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;
   localparam int OFFS_WIDTH = $clog2(STRB_WIDTH);
   localparam int IDX_WIDTH  = ADDR_WIDTH - OFFS_WIDTH;

   wr_state_e               wr_state, wr_next;
   rd_state_e               rd_state;
   logic                    run_q;
   logic [ADDR_WIDTH-1:0]   aw_addr_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [STRB_WIDTH-1:0]   wstrb_q;
   logic [1:0]              bresp_q;
   logic [1:0]              rresp_q;
   logic                    rd_err_q;
   logic                    aw_hs, w_hs, ar_hs, commit;
   logic [ADDR_WIDTH-1:0]   wr_addr;
   logic [DATA_WIDTH-1:0]   wr_data;
   logic [STRB_WIDTH-1:0]   wr_strb;
   logic                    wr_aligned, rd_aligned;
   logic [DATA_WIDTH-1:0]   mem_rdata;

   // run_q keeps every ready low during reset and lets them rise on the
   // first edge after release.
   assign s_axi_awready = run_q && (wr_state == W_IDLE || wr_state == W_NEED_ADDR);
   assign s_axi_wready  = run_q && (wr_state == W_IDLE || wr_state == W_NEED_DATA);
   assign s_axi_bvalid  = (wr_state == W_RESP);
   assign s_axi_bresp   = bresp_q;
   assign s_axi_arready = run_q && (rd_state == R_IDLE);
   assign s_axi_rvalid  = (rd_state == R_DATA);
   assign s_axi_rresp   = rresp_q;
   assign s_axi_rdata   = (rd_state == R_DATA && !rd_err_q) ? mem_rdata : '0;

   assign aw_hs = s_axi_awvalid && s_axi_awready;
   assign w_hs  = s_axi_wvalid  && s_axi_wready;
   assign ar_hs = s_axi_arvalid && s_axi_arready;

   // The commit cycle uses whichever half arrives now, else the latched half.
   assign wr_addr    = aw_hs ? s_axi_awaddr : aw_addr_q;
   assign wr_data    = w_hs  ? s_axi_wdata  : wdata_q;
   assign wr_strb    = w_hs  ? s_axi_wstrb  : wstrb_q;
   assign wr_aligned = (wr_addr[OFFS_WIDTH-1:0] == '0);
   assign rd_aligned = (s_axi_araddr[OFFS_WIDTH-1:0] == '0);

   // Write FSM next state and commit detection
   always_comb begin
      wr_next = wr_state;
      commit  = 1'b0;
      case (wr_state)
         W_IDLE: begin
            if (aw_hs && w_hs) begin
               wr_next = W_RESP;
               commit  = 1'b1;
            end else if (aw_hs) begin
               wr_next = W_NEED_DATA;
            end else if (w_hs) begin
               wr_next = W_NEED_ADDR;
            end
         end
         W_NEED_DATA: begin
            if (w_hs) begin
               wr_next = W_RESP;
               commit  = 1'b1;
            end
         end
         W_NEED_ADDR: begin
            if (aw_hs) begin
               wr_next = W_RESP;
               commit  = 1'b1;
            end
         end
         W_RESP: begin
            if (s_axi_bready) wr_next = W_IDLE;
         end
         default: wr_next = W_IDLE;
      endcase
   end

   // Write state, per-channel latches and response code
   always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
      if (s_axi_areset) begin
         run_q     <= 1'b0;
         wr_state  <= W_IDLE;
         aw_addr_q <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         bresp_q   <= RESP_OKAY;
      end else begin
         run_q    <= 1'b1;
         wr_state <= wr_next;
         if (aw_hs) aw_addr_q <= s_axi_awaddr;
         if (w_hs) begin
            wdata_q <= s_axi_wdata;
            wstrb_q <= s_axi_wstrb;
         end
         if (commit) bresp_q <= wr_aligned ? RESP_OKAY : RESP_SLVERR;
      end
   end

   // Read FSM: capture response on accept, hold until consumed
   always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
      if (s_axi_areset) begin
         rd_state <= R_IDLE;
         rresp_q  <= RESP_OKAY;
         rd_err_q <= 1'b0;
      end else begin
         case (rd_state)
            R_IDLE: begin
               if (ar_hs) begin
                  rd_state <= R_DATA;
                  rresp_q  <= rd_aligned ? RESP_OKAY : RESP_SLVERR;
                  rd_err_q <= !rd_aligned;
               end
            end
            R_DATA: begin
               if (s_axi_rready) rd_state <= R_IDLE;
            end
            default: rd_state <= R_IDLE;
         endcase
      end
   end

   axil_mem_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .IDX_WIDTH  (IDX_WIDTH)
   ) u_mem (
      .clk     (s_axi_aclk),
      .wr_en   (commit && wr_aligned),
      .wr_idx  (wr_addr[ADDR_WIDTH-1:OFFS_WIDTH]),
      .wr_data (wr_data),
      .wr_strb (wr_strb),
      .rd_en   (ar_hs),
      .rd_idx  (s_axi_araddr[ADDR_WIDTH-1:OFFS_WIDTH]),
      .rd_data (mem_rdata)
   );

endmodule
`default_nettype wire

// File: doc/axil_mem_slave.md
AXIL_MEM_SLAVE -- requirements
Module: axil_mem_slave

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data bus width in bits (32 or 64).
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, byte address width; depth = 2**ADDR_WIDTH / (DATA_WIDTH/8) words.
REQ-003 Ports, in order:
 s_axi_aclk  in  1  sole clock, all logic on rising edge.
 s_axi_areset  in  1  asynchronous, active-high reset.
 s_axi_awaddr  in  ADDR_WIDTH  write byte address.
 s_axi_awvalid  in  1 / s_axi_awready  out  1  write-address handshake.
 s_axi_wdata  in  DATA_WIDTH  write data.
 s_axi_wstrb  in  DATA_WIDTH/8  byte enables, bit i covers wdata[8i+7:8i].
 s_axi_wvalid  in  1 / s_axi_wready  out  1  write-data handshake.
 s_axi_bresp  out  2  write response code.
 s_axi_bvalid  out  1 / s_axi_bready  in  1  write-response handshake.
 s_axi_araddr  in  ADDR_WIDTH  read byte address.
 s_axi_arvalid  in  1 / s_axi_arready  out  1  read-address handshake.
 s_axi_rdata  out  DATA_WIDTH  read data.
 s_axi_rresp  out  2  read response code.
 s_axi_rvalid  out  1 / s_axi_rready  in  1  read-data handshake.
REQ-004 Single clock s_axi_aclk; reset s_axi_areset is asynchronous and active-high.

Function
REQ-005 Block SHALL be the AXI4-Lite responder (memory endpoint) on the far side of the team's AXI-Lite bus master port.
REQ-006 Transfer occurs on a channel only in a cycle with valid and ready both high.
REQ-007 Write FSM states: W_IDLE, W_NEED_DATA, W_NEED_ADDR, W_RESP.
REQ-008 W_IDLE: awready=1, wready=1; aw and w both accepted -> W_RESP; aw only -> W_NEED_DATA; w only -> W_NEED_ADDR.
REQ-009 W_NEED_DATA: awready=0, wready=1; on w accept -> W_RESP. W_NEED_ADDR: awready=1, wready=0; on aw accept -> W_RESP.
REQ-010 Address and data/strobe SHALL be latched on their own handshake; memory update and bvalid=1 occur on the cycle entering W_RESP (latency 1 after last of aw/w).
REQ-011 W_RESP: awready=0, wready=0, bvalid held at 1 with stable bresp until bready=1; then -> W_IDLE with bvalid=0 next cycle.
REQ-012 Only bytes with wstrb=1 SHALL be written; wstrb=0 all-bytes yields OKAY with no change.
REQ-013 Word index = addr[ADDR_WIDTH-1:log2(DATA_WIDTH/8)]; address with nonzero low byte-offset bits SHALL get resp SLVERR (2'b10), no memory write; otherwise OKAY (2'b00).
REQ-014 Read FSM states: R_IDLE (arready=1, rvalid=0), R_DATA (arready=0, rvalid=1).
REQ-015 On ar accept: rdata/rresp registered next cycle, -> R_DATA; held stable until rready=1, then -> R_IDLE.
REQ-016 Misaligned read SHALL return rdata=0, rresp=SLVERR.
REQ-017 Read and write FSMs independent; both may be active simultaneously.
REQ-018 Read address accepted in the same cycle a write commits to that word SHALL return the pre-write value.
REQ-019 Peak throughput: one write per 2 cycles, one read per 2 cycles.

Reset
REQ-020 On s_axi_areset=1, immediately: both FSMs to idle, awready=0, wready=0, arready=0, bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0.
REQ-021 Ready outputs SHALL rise on the first clock edge after reset deasserts.
REQ-022 Memory contents SHALL NOT be reset; reset mid-transaction discards the pending transaction with no partial write.

Structure
REQ-023 Package axil_pkg SHALL hold resp constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10 and both FSM state enums.
REQ-024 Storage SHALL be sub-module axil_mem_array: synchronous byte-enable write port, registered read port, no reset.

Verification
REQ-025 aw+w same cycle, addr 0x04, data 0xDEADBEEF, strb 4'hF -> bvalid next cycle, bresp 00; read 0x04 -> rdata 0xDEADBEEF, rresp 00.
REQ-026 w 3 cycles before aw (addr 0x08, data 0x11223344, strb 4'b0101) over prior 0xFFFFFFFF -> read 0x08 returns 0xFF22FF44.
REQ-027 Misaligned write 0x05 and read 0x06 -> bresp 10, rresp 10, rdata 0; word 0x04 unchanged.
REQ-028 bready held low 5 cycles -> bvalid and bresp stable, awready=wready=0 throughout; rready low likewise holds rdata.
REQ-029 Write 0x0C=0xA5A5A5A5 committing same cycle as ar 0x0C (old 0x0) -> rdata 0x0; subsequent read 0xA5A5A5A5.
REQ-030 Assert reset while in W_NEED_DATA -> bvalid=0 immediately, no memory change, readies high one cycle after release.
